pengo_input_conditioner: RTL and testbench
==========================================

Name: pengo_input_conditioner

Overview:
- Sits between the arcade key/joystick decoder and the Pac-Man-family machine core.
- Converts raw active-high player controls into the core's active-low IN0/IN1 bytes.
- Synchronises, debounces and cleans up opposing directions.
- Shapes coin inserts into frame-counted pulses so the Z80's once-per-vblank input poll always sees exactly one coin per insert.

Parameters:
- DEBOUNCE_CYCLES, 240000, clk cycles an input must be stable before the debounced value changes (10 ms at 24 MHz); counter width is $clog2(DEBOUNCE_CYCLES+1).
- COIN_FRAMES, 3, vblank rising edges the coin output stays asserted per accepted insert (range 1-15).
- COIN_GAP_FRAMES, 4, vblank rising edges the coin output must stay deasserted before another insert is accepted (range 1-15).
- AUTOFIRE_FRAMES, 4, half-period in vblank edges of autofire toggling (only used with PENGO_AUTOFIRE_EN).

Ports:
- clk  in  1  system clock (24 MHz domain of the machine core)
- reset  in  1  asynchronous, active-high reset
- raw_up / raw_down / raw_left / raw_right  in  1 each  active-high directions from the input decoder, asynchronous to clk
- raw_fire  in  1  active-high fire
- raw_coin1  in  1  active-high coin
- raw_start1 / raw_start2  in  1 each  active-high start buttons
- autofire_on  in  1  OSD autofire enable; ignored when the feature is compiled out
- v_blank  in  1  vertical blank from the machine core, clk domain
- in0_reg  out  8  active-low {fire,1,1,coin1,right,left,down,up}
- in1_reg  out  8  active-low {1,start2,start1,1,1,1,1,1}
- coin_busy  out  1  high while the coin FSM is not IDLE

Behaviour:
- Reset: all synchronisers, debounced values and counters cleared; coin FSM in IDLE; in0_reg = 8'hFF, in1_reg = 8'hFF, coin_busy = 0. Reset asserted mid-pulse aborts the pulse immediately; the coin output is not resumed after release.
- Sync: each raw input passes a 2-flop synchroniser before the debouncer.
- Debounce, per bit:
  - If the synced value equals the debounced value, the counter clears.
  - Otherwise the counter increments; when it reaches DEBOUNCE_CYCLES-1 the debounced value takes the synced value and the counter clears.
  - A glitch shorter than DEBOUNCE_CYCLES never propagates.
  - Latency from raw edge to debounced edge is DEBOUNCE_CYCLES+2 clk cycles.
- Opposing directions: if debounced up and down are both 1, both are output as released; left/right likewise. The non-conflicting axis is unaffected.
- Frame tick: a one-cycle pulse on the clk after v_blank goes 0->1 (registered edge detect).
- Coin FSM:
  - IDLE: on a debounced coin rising edge, go to PULSE with frame count 0. Holding coin does not retrigger; a new rising edge is required.
  - PULSE: coin output asserted; each tick increments the count; at COIN_FRAMES, clear the count and go to GAP.
  - GAP: coin output deasserted; each tick increments the count; at COIN_GAP_FRAMES, go to IDLE.
  - A coin edge arriving in PULSE or GAP is dropped, not queued.
- Same-cycle events: a tick and a coin edge in the same IDLE cycle start PULSE; that tick is not counted.
- Output register: in0_reg/in1_reg are registered, one cycle after the debounced/FSM values; constant bits are always 1.
- Start buttons and fire pass through debounce only.

Optional Feature:
- Macro: PENGO_AUTOFIRE_EN.
- Defined:
  - While autofire_on=1 and debounced fire=1, an autofire phase flop toggles every AUTOFIRE_FRAMES ticks, and fire output = phase.
  - The phase resets to 1 (pressed) on every fire rising edge, so the first frame always fires.
  - When autofire_on=0, fire passes through unchanged.
- Undefined: no phase logic is built; autofire_on is unused and fire is plain debounced.

Test Plan:
- Reset and idle: assert reset with all raw inputs 0 -> in0_reg=8'hFF, in1_reg=8'hFF, coin_busy=0; reset released with raw_up=1 held -> in0_reg=8'hFE exactly DEBOUNCE_CYCLES+3 clks later.
- Glitch rejection: raw_fire pulse of DEBOUNCE_CYCLES-5 clks -> in0_reg[7] stays 1; pulse held for DEBOUNCE_CYCLES+10 clks -> in0_reg[7]=0.
- Coin shaping: raw_coin1 held for 20 frames with defaults -> in0_reg[4]=0 for exactly 3 ticks, then 1; coin_busy high for 7 ticks; no second pulse while held.
- Coin spam: second coin edge 2 frames after the first -> dropped, single pulse only; edge 8 frames after the first -> second 3-frame pulse.
- SOCD: raw_left=raw_right=1, raw_up=1 -> in0_reg=8'hFE; release raw_left -> in0_reg=8'hF6 after the debounce delay.
- Autofire (macro defined, autofire_on=1, AUTOFIRE_FRAMES=4): hold fire 16 frames -> in0_reg[7] pattern 0,0,0,0,1,1,1,1 repeating. Macro undefined -> constant 0.

Source files
------------

// File: rtl/pengo_input_conditioner.sv
// pengo_input_conditioner: raw player controls -> synchronised, debounced, active-low IN0/IN1 bytes
// Ports: clk, reset (async, active-high); raw_* active-high controls, async to clk;
//   autofire_on OSD enable; v_blank frame strobe source (clk domain);
//   in0_reg {fire,1,1,coin1,right,left,down,up} and in1_reg {1,start2,start1,1,1,1,1,1}, both active-low;
//   coin_busy high while a coin pulse or its gap is in progress.
// Optional: define PENGO_AUTOFIRE_EN to build frame-based autofire on the fire button.
module pengo_input_conditioner #(
  parameter int DEBOUNCE_CYCLES = 240000,
  parameter int COIN_FRAMES     = 3,
  parameter int COIN_GAP_FRAMES = 4,
  parameter int AUTOFIRE_FRAMES = 4
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       raw_up,
  input  logic       raw_down,
  input  logic       raw_left,
  input  logic       raw_right,
  input  logic       raw_fire,
  input  logic       raw_coin1,
  input  logic       raw_start1,
  input  logic       raw_start2,
  input  logic       autofire_on,
  input  logic       v_blank,
  output logic [7:0] in0_reg,
  output logic [7:0] in1_reg,
  output logic       coin_busy
);
  localparam int CW = $clog2(DEBOUNCE_CYCLES + 1);
  typedef enum logic [1:0] {IDLE, PULSE, GAP} coin_state_t;
  // bit order: up, down, left, right, fire, coin1, start1, start2
  logic [7:0] w_raw, r_s1, r_s2, w_db;
  logic r_vb, w_tick, r_coin_prev, w_coin_rise, w_fire;
  logic w_up, w_down, w_left, w_right;
  coin_state_t r_state, w_state_nxt;
  logic [3:0] r_fcnt, w_fcnt_nxt;
  assign w_raw = {raw_start2, raw_start1, raw_coin1, raw_fire, raw_right, raw_left, raw_down, raw_up};
  always_ff @(posedge clk or posedge reset)
    if (reset) begin
      r_s1 <= '0;
      r_s2 <= '0;
    end else begin
      r_s1 <= w_raw;
      r_s2 <= r_s1;
    end
  for (genvar i = 0; i < 8; i++) begin : g_db
    logic r_db;
    logic [CW-1:0] r_cnt;
    always_ff @(posedge clk or posedge reset)
      if (reset) begin
        r_db  <= 1'b0;
        r_cnt <= '0;
      end else if (r_s2[i] == r_db) begin
        r_cnt <= '0;
      end else if (r_cnt == CW'(DEBOUNCE_CYCLES - 1)) begin
        r_db  <= r_s2[i];
        r_cnt <= '0;
      end else begin
        r_cnt <= r_cnt + CW'(1);
      end
    assign w_db[i] = r_db;
  end
  // opposing directions cancel each other out
  assign w_up    = w_db[0] & ~w_db[1];
  assign w_down  = w_db[1] & ~w_db[0];
  assign w_left  = w_db[2] & ~w_db[3];
  assign w_right = w_db[3] & ~w_db[2];
  assign w_tick      = v_blank & ~r_vb;
  assign w_coin_rise = w_db[5] & ~r_coin_prev;
  always_ff @(posedge clk or posedge reset)
    if (reset) begin
      r_vb        <= 1'b0;
      r_coin_prev <= 1'b0;
      r_state     <= IDLE;
      r_fcnt      <= '0;
    end else begin
      r_vb        <= v_blank;
      r_coin_prev <= w_db[5];
      r_state     <= w_state_nxt;
      r_fcnt      <= w_fcnt_nxt;
    end
  // a coin edge seen outside IDLE is dropped; a tick coinciding with the start is not counted
  always_comb begin
    w_state_nxt = r_state;
    w_fcnt_nxt  = r_fcnt;
    case (r_state)
      IDLE: if (w_coin_rise) begin
        w_state_nxt = PULSE;
        w_fcnt_nxt  = '0;
      end
      PULSE: if (w_tick) begin
        w_state_nxt = (r_fcnt == 4'(COIN_FRAMES - 1)) ? GAP : PULSE;
        w_fcnt_nxt  = (r_fcnt == 4'(COIN_FRAMES - 1)) ? 4'd0 : r_fcnt + 4'd1;
      end
      GAP: if (w_tick) begin
        w_state_nxt = (r_fcnt == 4'(COIN_GAP_FRAMES - 1)) ? IDLE : GAP;
        w_fcnt_nxt  = (r_fcnt == 4'(COIN_GAP_FRAMES - 1)) ? 4'd0 : r_fcnt + 4'd1;
      end
      default: begin
        w_state_nxt = IDLE;
        w_fcnt_nxt  = '0;
      end
    endcase
  end
  assign coin_busy = r_state != IDLE;
`ifdef PENGO_AUTOFIRE_EN
  logic r_fire_prev, r_phase;
  logic [3:0] r_af_cnt;
  // phase restarts pressed on every new press so the first frame always fires
  always_ff @(posedge clk or posedge reset)
    if (reset) begin
      r_fire_prev <= 1'b0;
      r_phase     <= 1'b1;
      r_af_cnt    <= '0;
    end else begin
      r_fire_prev <= w_db[4];
      if (w_db[4] & ~r_fire_prev) begin
        r_phase  <= 1'b1;
        r_af_cnt <= '0;
      end else if (autofire_on & w_db[4] & w_tick) begin
        r_af_cnt <= (r_af_cnt == 4'(AUTOFIRE_FRAMES - 1)) ? 4'd0 : r_af_cnt + 4'd1;
        r_phase  <= (r_af_cnt == 4'(AUTOFIRE_FRAMES - 1)) ? ~r_phase : r_phase;
      end
    end
  assign w_fire = (autofire_on & w_db[4]) ? r_phase : w_db[4];
`else
  logic w_unused;
  assign w_unused = autofire_on;
  assign w_fire   = w_db[4];
`endif
  always_ff @(posedge clk or posedge reset)
    if (reset) begin
      in0_reg <= 8'hFF;
      in1_reg <= 8'hFF;
    end else begin
      in0_reg <= ~{w_fire, 2'b00, r_state == PULSE, w_right, w_left, w_down, w_up};
      in1_reg <= ~{1'b0, w_db[7], w_db[6], 5'b00000};
    end
endmodule

// File: tb/tb_pengo_input_conditioner.sv
// tb_pengo_input_conditioner: scoreboard bench for pengo_input_conditioner
module tb_pengo_input_conditioner;
  localparam int DB = 16, CF = 3, GF = 4, AF = 4, FP = 40;
  typedef struct packed {logic [7:0] i0; logic [7:0] i1; logic b;} exp_t;
  logic clk = 0, reset = 1, af_on = 0, v_blank = 0;
  logic [7:0] raw = '0;
  logic [7:0] in0, in1;
  logic busy;
  int total = 0, bad = 0;
  exp_t q[$];
  pengo_input_conditioner #(.DEBOUNCE_CYCLES(DB), .COIN_FRAMES(CF), .COIN_GAP_FRAMES(GF), .AUTOFIRE_FRAMES(AF)) dut (
    .clk(clk), .reset(reset),
    .raw_up(raw[0]), .raw_down(raw[1]), .raw_left(raw[2]), .raw_right(raw[3]),
    .raw_fire(raw[4]), .raw_coin1(raw[5]), .raw_start1(raw[6]), .raw_start2(raw[7]),
    .autofire_on(af_on), .v_blank(v_blank),
    .in0_reg(in0), .in1_reg(in1), .coin_busy(busy)
  );
  always #5 clk = ~clk;
  initial forever begin
    repeat (FP - 8) @(negedge clk);
    v_blank = 1;
    repeat (8) @(negedge clk);
    v_blank = 0;
  end
  // reference model: a button's level is accepted once it has been seen, two clocks late,
  // unchanged for DB clocks; a coin insert owns CF+GF frame ticks (CF asserted, GF quiet)
  logic [7:0] m_db = '0, m_last = '0;
  int m_run[8];
  logic [7:0] hq[$];
  logic m_vb = 0, m_coin_prev = 0, m_fire_prev = 0;
  int m_left = 0, m_af = 0;
  task automatic model_reset();
    m_db = '0;
    m_last = '0;
    for (int i = 0; i < 8; i++) m_run[i] = 0;
    hq = '{8'h00, 8'h00};
    m_vb = 0;
    m_coin_prev = 0;
    m_fire_prev = 0;
    m_left = 0;
    m_af = 0;
  endtask
  always @(posedge clk) begin
    exp_t e;
    logic tick, fo, co, rise;
    logic [7:0] s;
    if (reset) begin
      model_reset();
      e = {8'hFF, 8'hFF, 1'b0};
    end else begin
      tick = v_blank && !m_vb;
      m_vb = v_blank;
`ifdef PENGO_AUTOFIRE_EN
      fo = (af_on && m_db[4]) ? ((m_af / AF) % 2 == 0) : m_db[4];
      if (m_db[4] && !m_fire_prev) m_af = 0;
      else if (af_on && m_db[4] && tick) m_af++;
`else
      fo = m_db[4];
`endif
      m_fire_prev = m_db[4];
      co = m_left > GF;
      e.i0 = ~{fo, 2'b00, co, m_db[3] && !m_db[2], m_db[2] && !m_db[3], m_db[1] && !m_db[0], m_db[0] && !m_db[1]};
      e.i1 = ~{1'b0, m_db[7], m_db[6], 5'b00000};
      rise = m_db[5] && !m_coin_prev;
      m_coin_prev = m_db[5];
      if (m_left == 0) begin
        if (rise) m_left = CF + GF;
      end else if (tick) m_left--;
      e.b = m_left > 0;
      s = hq.pop_front();
      hq.push_back(raw);
      for (int i = 0; i < 8; i++) begin
        if (s[i] == m_last[i]) m_run[i]++;
        else begin
          m_last[i] = s[i];
          m_run[i] = 1;
        end
        if (s[i] != m_db[i] && m_run[i] >= DB) m_db[i] = s[i];
      end
    end
    q.push_back(e);
  end
  task automatic chk(input string n, input logic [7:0] a, input logic [7:0] x);
    total++;
    if (a !== x) begin
      bad++;
      $display("FAIL %s t=%0t got=%h want=%h", n, $time, a, x);
    end
  endtask
  always @(negedge clk) begin
    exp_t e;
    if (q.size() > 0) begin
      e = q.pop_front();
      chk("in0_reg", in0, e.i0);
      chk("in1_reg", in1, e.i1);
      chk("coin_busy", {7'd0, busy}, {7'd0, e.b});
    end
  end
  task automatic cyc(input int n);
    repeat (n) @(negedge clk);
  endtask
  initial begin
    cyc(5);
    raw[0] = 1;
    reset = 0;
    cyc(60);
    raw = '0;
    cyc(40);
    raw[4] = 1;
    cyc(DB - 5);
    raw[4] = 0;
    cyc(40);
    raw[4] = 1;
    cyc(DB + 10);
    raw[4] = 0;
    cyc(40);
    raw[5] = 1;
    cyc(20 * FP);
    raw[5] = 0;
    cyc(6 * FP);
    raw[5] = 1;
    cyc(DB + 10);
    raw[5] = 0;
    cyc(2 * FP - DB - 10);
    raw[5] = 1;
    cyc(DB + 10);
    raw[5] = 0;
    cyc(6 * FP - DB - 10);
    raw[5] = 1;
    cyc(DB + 10);
    raw[5] = 0;
    cyc(10 * FP);
    raw = 8'b0000_1101;
    cyc(60);
    raw[2] = 0;
    cyc(60);
    raw = '0;
    cyc(60);
    af_on = 1;
    raw[4] = 1;
    cyc(16 * FP);
    raw[4] = 0;
    af_on = 0;
    cyc(60);
    raw[6] = 1;
    raw[7] = 1;
    cyc(40);
    raw = '0;
    cyc(40);
    repeat (3000) begin
      @(negedge clk);
      for (int i = 0; i < 8; i++) if ($urandom_range(0, 99) < 3) raw[i] = ~raw[i];
      if ($urandom_range(0, 499) == 0) af_on = ~af_on;
      if ($urandom_range(0, 1499) == 0) begin
        reset = 1;
        @(negedge clk);
        reset = 0;
      end
    end
    raw = '0;
    reset = 1;
    cyc(3);
    reset = 0;
    cyc(3);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
